// File: rtl/gpio_axil_ctrl.sv
// gpio_axil_ctrl: AXI4-Lite slave front-end for the GPIO register file.
// Arbitrates AXI write/read requests round-robin and runs one register
// access at a time on the reg_* interface; reads wait RD_LAT cycles.
// Optional build macro: GPIO_AXIL_SLVERR_EN (addresses >= REG_SPAN answer
// SLVERR without touching the register interface).
module gpio_axil_ctrl #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 32,
    parameter int          RD_LAT     = 1,
    parameter logic [31:0] REG_SPAN   = 32'h0000_0100
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [ADDR_WIDTH-1:0]     s_awaddr,
    input  logic                      s_awvalid,
    output logic                      s_awready,
    input  logic [DATA_WIDTH-1:0]     s_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_wstrb,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    output logic [1:0]                s_bresp,
    output logic                      s_bvalid,
    input  logic                      s_bready,
    input  logic [ADDR_WIDTH-1:0]     s_araddr,
    input  logic                      s_arvalid,
    output logic                      s_arready,
    output logic [DATA_WIDTH-1:0]     s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      s_rvalid,
    input  logic                      s_rready,
    output logic [31:0]               reg_addr,
    output logic [DATA_WIDTH-1:0]     reg_wdata,
    output logic                      reg_we,
    output logic [DATA_WIDTH/8-1:0]   reg_wstrb,
    input  logic [DATA_WIDTH-1:0]     reg_rdata
);

    localparam int         STRB_WIDTH = DATA_WIDTH / 8;
    // Counter reload: RD_WAIT lasts RD_LAT cycles, counting down to zero.
    localparam logic [2:0] LAT_M1     = 3'(RD_LAT - 1);
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_STB  = 3'd1,
        ST_WR_RSP  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_RD_RSP  = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_prio_wr;
    logic                    w_prio_wr_nxt;
    logic [2:0]              r_cnt;
    logic [2:0]              w_cnt_nxt;

    logic [31:0]             r_reg_addr;
    logic [31:0]             w_reg_addr_nxt;
    logic [DATA_WIDTH-1:0]   r_reg_wdata;
    logic [DATA_WIDTH-1:0]   w_reg_wdata_nxt;
    logic [STRB_WIDTH-1:0]   r_reg_wstrb;
    logic [STRB_WIDTH-1:0]   w_reg_wstrb_nxt;
    logic                    r_reg_we;
    logic                    w_reg_we_nxt;
    logic                    r_bvalid;
    logic                    w_bvalid_nxt;
    logic [1:0]              r_bresp;
    logic [1:0]              w_bresp_nxt;
    logic                    r_rvalid;
    logic                    w_rvalid_nxt;
    logic [1:0]              r_rresp;
    logic [1:0]              w_rresp_nxt;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [DATA_WIDTH-1:0]   w_rdata_nxt;

    logic                    w_aw_grant;
    logic                    w_ar_grant;
    logic                    w_wr_cand;
    logic                    w_rd_cand;
    logic [31:0]             w_awaddr_ext;
    logic [31:0]             w_araddr_ext;
    logic                    w_aw_err;
    logic                    w_ar_err;
    logic                    w_unused;

    // A write is only a candidate when address and data arrive together.
    assign w_wr_cand    = s_awvalid & s_wvalid;
    assign w_rd_cand    = s_arvalid;
    assign w_awaddr_ext = 32'(s_awaddr);
    assign w_araddr_ext = 32'(s_araddr);

`ifdef GPIO_AXIL_SLVERR_EN
    assign w_aw_err = (w_awaddr_ext >= REG_SPAN);
    assign w_ar_err = (w_araddr_ext >= REG_SPAN);
`else
    assign w_aw_err = 1'b0;
    assign w_ar_err = 1'b0;
`endif

    // Byte-lane bits of the address are dropped on reg_addr; REG_SPAN only
    // matters when decode errors are built in.
    assign w_unused = ^{w_awaddr_ext[1:0], w_araddr_ext[1:0], REG_SPAN};

    // Next-state, arbitration and next values of every registered output.
    always_comb begin
        w_state_nxt     = r_state;
        w_prio_wr_nxt   = r_prio_wr;
        w_cnt_nxt       = r_cnt;
        w_aw_grant      = 1'b0;
        w_ar_grant      = 1'b0;
        w_reg_addr_nxt  = r_reg_addr;
        w_reg_wdata_nxt = '0;
        w_reg_wstrb_nxt = '0;
        w_reg_we_nxt    = 1'b0;
        w_bvalid_nxt    = r_bvalid;
        w_bresp_nxt     = r_bresp;
        w_rvalid_nxt    = r_rvalid;
        w_rresp_nxt     = r_rresp;
        w_rdata_nxt     = r_rdata;

        case (r_state)
            ST_IDLE: begin
                if (rstn && w_wr_cand && (!w_rd_cand || r_prio_wr)) begin
                    w_aw_grant     = 1'b1;
                    w_prio_wr_nxt  = 1'b0;
                    w_reg_addr_nxt = {w_awaddr_ext[31:2], 2'b00};
                    if (w_aw_err) begin
                        w_state_nxt  = ST_WR_RSP;
                        w_bvalid_nxt = 1'b1;
                        w_bresp_nxt  = RESP_SLVERR;
                    end else begin
                        w_state_nxt     = ST_WR_STB;
                        w_reg_we_nxt    = 1'b1;
                        w_reg_wdata_nxt = s_wdata;
                        w_reg_wstrb_nxt = s_wstrb;
                    end
                end else if (rstn && w_rd_cand) begin
                    w_ar_grant     = 1'b1;
                    w_prio_wr_nxt  = 1'b1;
                    w_reg_addr_nxt = {w_araddr_ext[31:2], 2'b00};
                    if (w_ar_err) begin
                        w_state_nxt  = ST_RD_RSP;
                        w_rvalid_nxt = 1'b1;
                        w_rresp_nxt  = RESP_SLVERR;
                        w_rdata_nxt  = '0;
                    end else begin
                        w_state_nxt = ST_RD_WAIT;
                        w_cnt_nxt   = LAT_M1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WR_STB: begin
                w_state_nxt  = ST_WR_RSP;
                w_bvalid_nxt = 1'b1;
                w_bresp_nxt  = RESP_OKAY;
            end
            ST_WR_RSP: begin
                if (s_bready) begin
                    w_state_nxt  = ST_IDLE;
                    w_bvalid_nxt = 1'b0;
                    w_bresp_nxt  = RESP_OKAY;
                end else begin
                    w_state_nxt  = ST_WR_RSP;
                end
            end
            ST_RD_WAIT: begin
                if (r_cnt == 3'd0) begin
                    w_state_nxt  = ST_RD_RSP;
                    w_rvalid_nxt = 1'b1;
                    w_rresp_nxt  = RESP_OKAY;
                    w_rdata_nxt  = reg_rdata;
                end else begin
                    w_cnt_nxt    = r_cnt - 3'd1;
                end
            end
            ST_RD_RSP: begin
                if (s_rready) begin
                    w_state_nxt  = ST_IDLE;
                    w_rvalid_nxt = 1'b0;
                    w_rresp_nxt  = RESP_OKAY;
                    w_rdata_nxt  = '0;
                end else begin
                    w_state_nxt  = ST_RD_RSP;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_bvalid_nxt = 1'b0;
                w_rvalid_nxt = 1'b0;
            end
        endcase
    end

    // State, round-robin flag, read-latency counter and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_prio_wr   <= 1'b1;
            r_cnt       <= 3'd0;
            r_reg_addr  <= 32'd0;
            r_reg_wdata <= '0;
            r_reg_wstrb <= '0;
            r_reg_we    <= 1'b0;
            r_bvalid    <= 1'b0;
            r_bresp     <= 2'b00;
            r_rvalid    <= 1'b0;
            r_rresp     <= 2'b00;
            r_rdata     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_prio_wr   <= w_prio_wr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_reg_addr  <= w_reg_addr_nxt;
            r_reg_wdata <= w_reg_wdata_nxt;
            r_reg_wstrb <= w_reg_wstrb_nxt;
            r_reg_we    <= w_reg_we_nxt;
            r_bvalid    <= w_bvalid_nxt;
            r_bresp     <= w_bresp_nxt;
            r_rvalid    <= w_rvalid_nxt;
            r_rresp     <= w_rresp_nxt;
            r_rdata     <= w_rdata_nxt;
        end
    end

    // Readys are the only combinational outputs: same-cycle grant in IDLE.
    assign s_awready = w_aw_grant;
    assign s_wready  = w_aw_grant;
    assign s_arready = w_ar_grant;

    assign s_bvalid  = r_bvalid;
    assign s_bresp   = r_bresp;
    assign s_rvalid  = r_rvalid;
    assign s_rresp   = r_rresp;
    assign s_rdata   = r_rdata;
    assign reg_addr  = r_reg_addr;
    assign reg_wdata = r_reg_wdata;
    assign reg_wstrb = r_reg_wstrb;
    assign reg_we    = r_reg_we;

endmodule

// File: tb/tb_gpio_axil_ctrl.sv
// Directed self-checking bench for gpio_axil_ctrl with a response scoreboard
// and a small register-file model behind the reg_* interface.
module tb_gpio_axil_ctrl;

    localparam int RD_LAT = 1;

    logic        clk;
    logic        rstn;
    logic [31:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;
    logic [31:0] reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_we;
    logic [3:0]  reg_wstrb;
    logic [31:0] reg_rdata;

    gpio_axil_ctrl #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .RD_LAT     (RD_LAT),
        .REG_SPAN   (32'h0000_0100)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .s_awaddr  (s_awaddr),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_wstrb (reg_wstrb),
        .reg_rdata (reg_rdata)
    );

    typedef struct {
        bit          is_wr;
        logic [1:0]  resp;
        logic [31:0] data;
        int          lat;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wexp_t;

    exp_t        exp_q[$];
    wexp_t       wexp_q[$];
    int          n_pass  = 0;
    int          n_fail  = 0;
    int          n_total = 0;
    int          we_count = 0;
    logic [31:0] mem [0:63];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model: byte-enabled write on the clock, combinational read.
    always @(posedge clk) begin
        if (reg_we === 1'b1) begin
            for (int b = 0; b < 4; b++) begin
                if (reg_wstrb[b]) mem[reg_addr[7:2]][8*b +: 8] <= reg_wdata[8*b +: 8];
            end
        end
    end
    assign reg_rdata = mem[reg_addr[7:2]];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every reg_we pulse must match the oldest expected register write.
    always @(negedge clk) begin
        if (reg_we === 1'b1) begin
            wexp_t w;
            we_count++;
            chk("we_expected", 64'(wexp_q.size() > 0), 64'd1);
            if (wexp_q.size() > 0) begin
                w = wexp_q.pop_front();
                chk("we_addr", 64'(reg_addr), 64'(w.addr));
                chk("we_data", 64'(reg_wdata), 64'(w.data));
                chk("we_strb", 64'(reg_wstrb), 64'(w.strb));
            end
        end
    end

    task automatic wait_grant(output bit is_wr);
        int n;
        bit got;
        n = 0;
        #1;
        got = s_awready || s_arready;
        while (!got && n < 40) begin
            @(negedge clk); #1;
            n++;
            got = s_awready || s_arready;
        end
        chk("grant_seen", 64'(got), 64'd1);
        chk("single_grant", 64'(s_awready && s_arready), 64'd0);
        if (s_awready) chk("wready_with_awready", 64'(s_wready), 64'd1);
        is_wr = s_awready;
    endtask

    task automatic wait_resp();
        int n;
        bit got;
        exp_t e;
        n = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk); #1;
            n++;
            got = s_bvalid || s_rvalid;
        end
        chk("resp_seen", 64'(got), 64'd1);
        chk("resp_expected", 64'(exp_q.size() > 0), 64'd1);
        if (got && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("resp_kind", 64'(s_bvalid), 64'(e.is_wr));
            chk("resp_lat", 64'(n), 64'(e.lat));
            if (e.is_wr) begin
                chk("bresp", 64'(s_bresp), 64'(e.resp));
            end else begin
                chk("rresp", 64'(s_rresp), 64'(e.resp));
                chk("rdata", 64'(s_rdata), 64'(e.data));
            end
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] er, input int el, input bit ewe);
        bit    g;
        exp_t  e;
        wexp_t w;
        @(negedge clk);
        s_awaddr = a; s_wdata = d; s_wstrb = s;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
        wait_grant(g);
        chk("wr_granted", 64'(g), 64'd1);
        if (ewe) begin
            w.addr = a & ~32'h3; w.data = d; w.strb = s;
            wexp_q.push_back(w);
        end
        e.is_wr = 1'b1; e.resp = er; e.data = 32'h0; e.lat = el;
        exp_q.push_back(e);
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        wait_resp();
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [31:0] ed,
                            input logic [1:0] er, input int el);
        bit   g;
        exp_t e;
        @(negedge clk);
        s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b1;
        wait_grant(g);
        chk("rd_granted", 64'(g), 64'd0);
        e.is_wr = 1'b0; e.resp = er; e.data = ed; e.lat = el;
        exp_q.push_back(e);
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        wait_resp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit    g;
        int    n;
        int    wi;
        int    ri;
        int    we0;
        exp_t  e;
        wexp_t w;

        for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
        mem[0] = 32'h1234_5678;
        rstn = 1'b0;
        s_awaddr = 32'h0; s_awvalid = 1'b0; s_wdata = 32'h0; s_wstrb = 4'h0; s_wvalid = 1'b0;
        s_bready = 1'b0; s_araddr = 32'h0; s_arvalid = 1'b0; s_rready = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_awready", 64'(s_awready), 64'd0);
        chk("rst_arready", 64'(s_arready), 64'd0);
        chk("rst_bvalid", 64'(s_bvalid), 64'd0);
        chk("rst_rvalid", 64'(s_rvalid), 64'd0);
        chk("rst_reg_we", 64'(reg_we), 64'd0);
        chk("rst_reg_addr", 64'(reg_addr), 64'd0);
        chk("rst_reg_wdata", 64'(reg_wdata), 64'd0);
        chk("rst_rdata", 64'(s_rdata), 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Basic write, strobed write, reads (one unaligned).
        axi_write(32'h04, 32'hA5A5_0F0F, 4'hF, 2'b00, 2, 1'b1);
        axi_write(32'h0C, 32'hFFFF_FFFF, 4'b0101, 2'b00, 2, 1'b1);

        // AW without W waits and does not block a read.
        @(negedge clk);
        s_awaddr = 32'h40; s_awvalid = 1'b1; s_wvalid = 1'b0;
        #1;
        chk("aw_alone_not_ready", 64'(s_awready), 64'd0);
        axi_read(32'h00, 32'h1234_5678, 2'b00, RD_LAT + 1);
        @(negedge clk); #1;
        chk("aw_alone_still_waiting", 64'(s_awready), 64'd0);
        s_awvalid = 1'b0;
        axi_read(32'h0E, 32'hC0FF_00FF, 2'b00, RD_LAT + 1);
        axi_read(32'h04, 32'hA5A5_0F0F, 2'b00, RD_LAT + 1);

        // Both channels valid every arbitration: strict W,R alternation.
        we0 = we_count;
        wi = 0; ri = 0;
        @(negedge clk);
        s_awaddr = 32'h10; s_wdata = 32'h0000_1000; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        s_araddr = 32'h00; s_arvalid = 1'b1; s_bready = 1'b1; s_rready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_grant(g);
            chk("rr_order", 64'(g), 64'((k % 2) == 0));
            if (g) begin
                w.addr = s_awaddr; w.data = s_wdata; w.strb = 4'hF;
                wexp_q.push_back(w);
                e.is_wr = 1'b1; e.resp = 2'b00; e.data = 32'h0; e.lat = 2;
            end else begin
                e.is_wr = 1'b0; e.resp = 2'b00; e.data = 32'h1234_5678; e.lat = RD_LAT + 1;
            end
            exp_q.push_back(e);
            @(posedge clk); #1;
            if (g) begin
                wi++;
                if (wi == 4) begin
                    s_awvalid = 1'b0; s_wvalid = 1'b0;
                end else begin
                    s_awaddr = s_awaddr + 32'h4; s_wdata = s_wdata + 32'h1;
                end
            end else begin
                ri++;
                if (ri == 4) s_arvalid = 1'b0;
            end
            wait_resp();
        end
        chk("rr_we_count", 64'(we_count - we0), 64'd4);

        // Write response held back by bready low for 5 cycles.
        @(negedge clk);
        s_awaddr = 32'h20; s_wdata = 32'hDEAD_BEEF; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b0;
        wait_grant(g);
        chk("stall_wr_granted", 64'(g), 64'd1);
        w.addr = 32'h20; w.data = 32'hDEAD_BEEF; w.strb = 4'hF;
        wexp_q.push_back(w);
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!s_bvalid && n < 10);
        chk("stall_bvalid_lat", 64'(n), 64'd2);
        s_arvalid = 1'b1; s_araddr = 32'h0;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_awaddr = 32'h24;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("stall_bvalid", 64'(s_bvalid), 64'd1);
            chk("stall_bresp", 64'(s_bresp), 64'd0);
            chk("stall_awready", 64'(s_awready), 64'd0);
            chk("stall_arready", 64'(s_arready), 64'd0);
            chk("stall_reg_wdata", 64'(reg_wdata), 64'd0);
        end
        s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
        s_bready = 1'b1;
        @(negedge clk); #1;
        chk("stall_bvalid_cleared", 64'(s_bvalid), 64'd0);

        // Reset during RD_WAIT drops the read; a fresh read then works.
        @(negedge clk);
        s_araddr = 32'h08; s_arvalid = 1'b1; s_rready = 1'b1;
        wait_grant(g);
        chk("rst_rd_granted", 64'(g), 64'd0);
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        rstn = 1'b0;
        #1;
        chk("rst_mid_rvalid", 64'(s_rvalid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("rst_hold_rvalid", 64'(s_rvalid), 64'd0);
        end
        rstn = 1'b1;
        axi_read(32'h08, 32'hC0DE_0002, 2'b00, RD_LAT + 1);

`ifdef GPIO_AXIL_SLVERR_EN
        // Out-of-span accesses answer SLVERR after one cycle.
        we0 = we_count;
        axi_write(32'h200, 32'h5555_AAAA, 4'hF, 2'b10, 1, 1'b0);
        axi_read(32'h200, 32'h0, 2'b10, 1);
        chk("slverr_no_we", 64'(we_count - we0), 64'd0);
`endif

        repeat (3) @(negedge clk);
        chk("wexp_drained", 64'(wexp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
